qadd_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational sign-magnitude fixed-point adder (`qadd`, sign bit plus N-1 magnitude bits, Q fractional bits) among R requesters. Each requester presents an operand pair through a valid/ready handshake. The block grants one requester at a time, registers the operands, and captures the adder result. It returns the sum tagged with the requester index through a valid/ready response port. It sits between the filter/control lanes and the single shared adder instance.

---
 rtl/qadd_arb_pkg.sv | 14 +
 rtl/qadd_arbiter_if.sv | 33 +++
 rtl/qadd.sv | 36 +++
 rtl/qadd_rr_pick.sv | 30 +++
 rtl/qadd_arbiter.sv | 107 ++++++++++
 tb/tb_qadd_arbiter.sv | 244 ++++++++++++++++++++++++
 6 files changed

// File: rtl/qadd_arb_pkg.sv
// Shared types and defaults for the qadd_arbiter slice: FSM state encoding
// and the default word/fraction widths of the shared sign-magnitude adder.
package qadd_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    localparam int QADD_N = 32;
    localparam int QADD_Q = 15;

endpackage

// File: rtl/qadd_arbiter_if.sv
// Request/response bundle between the requester lanes and qadd_arbiter.
// rsp_ovf exists only when QADD_ARB_OVF_EN is defined.
interface qadd_arbiter_if
    import qadd_arb_pkg::*;
#(
    parameter int N = QADD_N,
    parameter int R = 4
);
    localparam int IDW = $clog2(R);

    logic [R-1:0]   req_valid;
    logic [R-1:0]   req_ready;
    logic [R*N-1:0] req_a;
    logic [R*N-1:0] req_b;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [IDW-1:0] rsp_id;
    logic [N-1:0]   rsp_c;
`ifdef QADD_ARB_OVF_EN
    logic           rsp_ovf;

    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_c, rsp_ovf);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_c, rsp_ovf);
`else
    modport master (output req_valid, req_a, req_b, rsp_ready,
                    input  req_ready, rsp_valid, rsp_id, rsp_c);
    modport slave  (input  req_valid, req_a, req_b, rsp_ready,
                    output req_ready, rsp_valid, rsp_id, rsp_c);
`endif

endinterface

// File: rtl/qadd.sv
// Combinational sign-magnitude fixed-point adder (sign bit + N-1 magnitude bits).
// Same-sign sums wrap in magnitude; a zero difference is returned as +0.
module qadd #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] c
);
    // Q only fixes the binary point; the magnitude arithmetic is independent of it.
    if (Q > N - 1) begin : g_q_invalid
        $error("qadd: Q exceeds the magnitude width");
    end

    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;

    assign mag_a = a[N-2:0];
    assign mag_b = b[N-2:0];

    always_comb begin
        c = '0;
        if (a[N-1] == b[N-1]) begin
            c[N-2:0] = mag_a + mag_b;
            c[N-1]   = a[N-1];
        end else if (mag_a > mag_b) begin
            c[N-2:0] = mag_a - mag_b;
            c[N-1]   = a[N-1];
        end else begin
            c[N-2:0] = mag_b - mag_a;
            c[N-1]   = (mag_b != mag_a) & b[N-1];
        end
    end

endmodule

// File: rtl/qadd_rr_pick.sv
// Combinational round-robin picker: first set request bit at or above ptr,
// wrapping modulo R; returns one-hot grant, winner index and an any-valid flag.
module qadd_rr_pick #(
    parameter int R   = 4,
    parameter int IDW = $clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   grant,
    output logic [IDW-1:0] winner,
    output logic           any
);
    int idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int k = 0; k < R; k++) begin
            idx = (int'(ptr) + k) % R;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/qadd_arbiter.sv
// Round-robin arbiter/sequencer sharing one qadd among R requesters.
// Define QADD_ARB_OVF_EN to add the registered rsp_ovf magnitude-overflow flag.
module qadd_arbiter
    import qadd_arb_pkg::*;
#(
    parameter int N = QADD_N,
    parameter int Q = QADD_Q,
    parameter int R = 4
) (
    input  logic           clk,
    input  logic           rst,
    qadd_arbiter_if.slave  bus,
    output logic           busy
);
    localparam int IDW = $clog2(R);

    arb_state_e     state;
    arb_state_e     state_d;
    logic [IDW-1:0] ptr;
    logic [R-1:0]   grant;
    logic [IDW-1:0] winner;
    logic           any;

    logic [N-1:0]   a_p0;
    logic [N-1:0]   b_p0;
    logic [IDW-1:0] id_p0;
    logic [N-1:0]   sum_c;

`ifdef QADD_ARB_OVF_EN
    function automatic logic ovf_flag(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] mag_sum;
        mag_sum = {1'b0, a[N-2:0]} + {1'b0, b[N-2:0]};
        return (a[N-1] == b[N-1]) & mag_sum[N-1];
    endfunction
`endif

    qadd_rr_pick #(.R(R), .IDW(IDW)) u_pick (
        .req    (bus.req_valid),
        .ptr    (ptr),
        .grant  (grant),
        .winner (winner),
        .any    (any)
    );

    qadd #(.N(N), .Q(Q)) u_qadd (
        .a (a_p0),
        .b (b_p0),
        .c (sum_c)
    );

    always_comb begin
        state_d       = state;
        bus.req_ready = '0;
        case (state)
            IDLE: begin
                if (any) begin
                    bus.req_ready = grant;
                    state_d       = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP:    if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // p0: operands and requester index captured at the grant edge
    always_ff @(posedge clk) begin
        if (state == IDLE && any) begin
            a_p0  <= bus.req_a[int'(winner)*N +: N];
            b_p0  <= bus.req_b[int'(winner)*N +: N];
            id_p0 <= winner;
        end
    end

    // p1: adder result registered into the response port
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= '0;
            bus.rsp_c     <= '0;
`ifdef QADD_ARB_OVF_EN
            bus.rsp_ovf   <= 1'b0;
`endif
        end else begin
            state <= state_d;
            if (state == IDLE && any) begin
                ptr <= (winner == IDW'(R - 1)) ? '0 : winner + 1'b1;
            end
            if (state == EXEC) begin
                bus.rsp_c     <= sum_c;
                bus.rsp_id    <= id_p0;
                bus.rsp_valid <= 1'b1;
`ifdef QADD_ARB_OVF_EN
                bus.rsp_ovf   <= ovf_flag(a_p0, b_p0);
`endif
            end else if (state == RESP && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qadd_arbiter.sv
// Directed bench for qadd_arbiter: expected responses are queued at grant time
// from a signed-integer reference adder and popped when rsp_valid appears.
module tb_qadd_arbiter;
    localparam int N   = 32;
    localparam int Q   = 15;
    localparam int R   = 4;
    localparam int IDW = $clog2(R);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [N-1:0]   c;
        logic           ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic busy;
    exp_t sb[$];
    exp_t last;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    qadd_arbiter_if #(.N(N), .R(R)) bus ();

    qadd_arbiter #(.N(N), .Q(Q), .R(R)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [N-1:0] model_add(input logic [N-1:0] a, input logic [N-1:0] b);
        longint sa, sb_v, s, m;
        logic [63:0] mv;
        logic [N-1:0] r;
        sa   = a[N-1] ? -longint'(a[N-2:0]) : longint'(a[N-2:0]);
        sb_v = b[N-1] ? -longint'(b[N-2:0]) : longint'(b[N-2:0]);
        s    = sa + sb_v;
        m    = (s < 0) ? -s : s;
        mv   = m;
        r[N-1]   = (s < 0);
        r[N-2:0] = mv[N-2:0];
        return r;
    endfunction

    function automatic logic model_ovf(input logic [N-1:0] a, input logic [N-1:0] b);
        longint ma, mb;
        ma = longint'(a[N-2:0]);
        mb = longint'(b[N-2:0]);
        return (a[N-1] == b[N-1]) && ((ma + mb) >= (longint'(1) << (N - 1)));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b);
        bus.req_valid[i]        = 1'b1;
        bus.req_a[i*N +: N]     = a;
        bus.req_b[i*N +: N]     = b;
    endtask

    task automatic do_reset(input string tag);
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_id"},    bus.rsp_id,    0);
        check({tag, "_rsp_c"},     bus.rsp_c,     0);
        check({tag, "_busy"},      busy,          0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
`ifdef QADD_ARB_OVF_EN
        check({tag, "_rsp_ovf"},   bus.rsp_ovf,   0);
`endif
        rst = 1'b0;
    endtask

    // Called on a negedge in IDLE with requests set up; returns on the RESP negedge.
    task automatic op(input int idx, input bit drop, input string tag);
        exp_t e;
        logic [R-1:0] g;
        g      = '0;
        g[idx] = 1'b1;
        #1;
        check({tag, "_ready"}, bus.req_ready, g);
        e.id  = IDW'(idx);
        e.c   = model_add(bus.req_a[idx*N +: N], bus.req_b[idx*N +: N]);
        e.ovf = model_ovf(bus.req_a[idx*N +: N], bus.req_b[idx*N +: N]);
        sb.push_back(e);
        step();
        if (drop) bus.req_valid[idx] = 1'b0;
        check({tag, "_exec_busy"},  busy,          1);
        check({tag, "_exec_valid"}, bus.rsp_valid, 0);
        check({tag, "_exec_ready"}, bus.req_ready, 0);
        step();
        check({tag, "_rsp_valid"}, bus.rsp_valid, 1);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e    = sb.pop_front();
            last = e;
            check({tag, "_rsp_id"}, bus.rsp_id, e.id);
            check({tag, "_rsp_c"},  bus.rsp_c,  e.c);
`ifdef QADD_ARB_OVF_EN
            check({tag, "_rsp_ovf"}, bus.rsp_ovf, e.ovf);
`endif
        end
    endtask

    initial begin
        logic [N-1:0] ra;
        logic [N-1:0] rb;
        int ri;

        do_reset("reset");

        // Single request from requester 0: 1.0 + 0.5
        set_req(0, 32'h0000_8000, 32'h0000_4000);
        op(0, 1'b1, "single");
        check("single_c_const", bus.rsp_c, 32'h0000_C000);

        // Negative operands from requester 2
        set_req(2, 32'h8000_8000, 32'h8000_8000);
        step();
        op(2, 1'b1, "neg");
        check("neg_c_const", bus.rsp_c, 32'h8001_0000);
        check("neg_id_const", bus.rsp_id, 2);
`ifdef QADD_ARB_OVF_EN
        check("neg_ovf_const", bus.rsp_ovf, 0);
`endif

        // Round-robin with every requester continuously valid
        do_reset("reset2");
        for (int i = 0; i < R; i++) set_req(i, 32'h0000_1000 * (i + 1), 32'h8000_0100 * (i + 1));
        op(0, 1'b0, "rr0");
        step();
        op(1, 1'b0, "rr1");
        step();
        op(2, 1'b0, "rr2");
        step();
        op(3, 1'b0, "rr3");
        step();
        op(0, 1'b0, "rr4");
        bus.req_valid = '0;
        step();
        check("rr_idle_ready", bus.req_ready, 0);
        check("rr_idle_busy", busy, 0);
        set_req(1, 32'h0001_0000, 32'h0000_0001);
        op(1, 1'b1, "rr_p1");
        set_req(0, 32'h0000_0003, 32'h0000_0004);
        set_req(3, 32'h8000_0005, 32'h0000_0009);
        step();
        op(3, 1'b1, "rr_wrap3");

        // Backpressure: hold the response for 5 cycles while requester 1 waits
        step();
        bus.rsp_ready = 1'b0;
        op(0, 1'b1, "bp");
        set_req(1, 32'h0000_0011, 32'h8000_0022);
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_c",     bus.rsp_c,     last.c);
            check("bp_hold_id",    bus.rsp_id,    last.id);
            check("bp_hold_ready", bus.req_ready, 0);
        end
        bus.rsp_ready = 1'b1;
        step();
        op(1, 1'b1, "bp_next");

        // Reset while the granted operation sits in EXEC
        step();
        set_req(1, 32'h0000_0777, 32'h0000_0111);
        #1;
        check("rstmid_grant", bus.req_ready, 4'b0010);
        step();
        check("rstmid_exec_busy", busy, 1);
        rst           = 1'b1;
        bus.req_valid = '0;
        step();
        check("rstmid_valid", bus.rsp_valid, 0);
        check("rstmid_busy",  busy,          0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("rstmid_no_rsp", bus.rsp_valid, 0);
        end
        set_req(1, 32'h0000_0002, 32'h0000_0003);
        set_req(3, 32'h0000_0004, 32'h0000_0005);
        op(1, 1'b1, "rstmid_ptr0");
        bus.req_valid[3] = 1'b0;

`ifdef QADD_ARB_OVF_EN
        step();
        set_req(2, 32'h7FFF_FFFF, 32'h0000_0001);
        op(2, 1'b1, "ovf_same");
        check("ovf_same_const", bus.rsp_ovf, 1);
        step();
        set_req(2, 32'h7FFF_FFFF, 32'h8000_0001);
        op(2, 1'b1, "ovf_opp");
        check("ovf_opp_const", bus.rsp_ovf, 0);
`endif

        // Random operands on a single active requester
        for (int t = 0; t < 6; t++) begin
            step();
            ri    = $urandom_range(0, R - 1);
            ra    = $urandom;
            rb    = $urandom;
            ra[0] = 1'b1;
            set_req(ri, ra, rb);
            op(ri, 1'b1, "rand");
        end

        step();
        check("end_sb_empty", sb.size(), 0);
        check("end_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
